// File: rtl/uart_tx.sv
// uart_tx: UART transmitter that sends start, LSB-first data, optional parity and stop bits.
// Define UART_TX_PARITY_EN to build in the parity bit (PAR_EN / PAR_TYP).
module uart_tx #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [4:0]        prescale,
  output logic              TX_OUT,
  output logic              Busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [4:0]        pre_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              tx_q;
  logic              busy_q;
  logic              bit_end;

`ifdef UART_TX_PARITY_EN
  logic              par_en_q;
  logic              par_q;
`else
  logic              unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  // A prescale of 0 latches as 0, and 0 - 1 wraps to 31: a 32-cycle bit.
  assign bit_end = (cnt_q == pre_q - 5'd1);

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  // Frame sequencer: registered line and busy, settings frozen at accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          bit_q <= '0;
          if (DATA_VALID) begin
            sh_q     <= P_DATA;
            pre_q    <= prescale;
`ifdef UART_TX_PARITY_EN
            par_en_q <= PAR_EN;
            par_q    <= (^P_DATA) ^ PAR_TYP;
`endif
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx frames cycle by cycle against a bit-list model.
// Parity expectations follow UART_TX_PARITY_EN as the DUT is built.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] prescale;
  logic       TX_OUT;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(.DATA_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit par_on(input logic pen);
`ifdef UART_TX_PARITY_EN
    return pen;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbits(input logic pen);
    return par_on(pen) ? 11 : 10;
  endfunction

  function automatic int pcyc(input logic [4:0] pre);
    return (pre == 5'd0) ? 32 : int'(pre);
  endfunction

  // Bit i of the frame on the wire: start, data LSB first, parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input logic pen,
                                   input logic pt, input int i);
    int ones;
    ones = 0;
    for (int j = 0; j < 8; j++) ones += int'(d[j]);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && par_on(pen)) return pt ? (ones % 2 == 0) : (ones % 2 == 1);
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic pen,
                             input logic pt, input logic [4:0] pre,
                             input bit keep);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = pt;
    prescale   = pre;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (!keep) DATA_VALID = 1'b0;
  endtask

  // Called just after the accept edge; checks every frame cycle and the idle one.
  task automatic check_frame(input logic [7:0] d, input logic pen,
                             input logic pt, input logic [4:0] pre,
                             input bit scr);
    int p;
    int n;
    p = pcyc(pre);
    n = nbits(pen) * p;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      chk("tx", {31'd0, TX_OUT}, {31'd0, exp_bit(d, pen, pt, c / p)});
      chk("busy", {31'd0, Busy}, 32'd1);
      if (scr && c == 1) begin
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        prescale   = 5'($urandom);
        DATA_VALID = 1'b1;
      end
      if (scr && c == 3) DATA_VALID = 1'b0;
    end
    @(negedge CLK);
    chk("idle_tx", {31'd0, TX_OUT}, 32'd1);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pen;
    logic       pt;
    logic [4:0] pre;

    RST        = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b1;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 5'd4;

    @(negedge CLK);
    chk("rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    chk("rst_dv_busy", {31'd0, Busy}, 32'd0);
    DATA_VALID = 1'b0;
    RST        = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);
    chk("post_rst_tx", {31'd0, TX_OUT}, 32'd1);

    start_frame(8'hA5, 1'b1, 1'b0, 5'd4, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 5'd4, 1'b0);

    start_frame(8'hA5, 1'b1, 1'b1, 5'd4, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b1, 5'd4, 1'b0);

    start_frame(8'h01, 1'b0, 1'b0, 5'd0, 1'b0);
    check_frame(8'h01, 1'b0, 1'b0, 5'd0, 1'b0);

    start_frame(8'h3C, 1'b0, 1'b0, 5'd2, 1'b1);
    #2 P_DATA = 8'hC3;
    check_frame(8'h3C, 1'b0, 1'b0, 5'd2, 1'b0);
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
    check_frame(8'hC3, 1'b0, 1'b0, 5'd2, 1'b0);

    start_frame(8'hFF, 1'b0, 1'b0, 5'd3, 1'b0);
    for (int c = 0; c < 4 * 3 + 1; c++) @(negedge CLK);
    chk("mid_bit3_tx", {31'd0, TX_OUT}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_tx", {31'd0, TX_OUT}, 32'd1);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_idle", {31'd0, Busy}, 32'd0);

    start_frame(8'h55, 1'b1, 1'b0, 5'd3, 1'b0);
    check_frame(8'h55, 1'b1, 1'b0, 5'd3, 1'b0);

    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      pen = 1'($urandom);
      pt  = 1'($urandom);
      pre = 5'($urandom_range(0, 9));
      start_frame(d, pen, pt, pre, 1'b0);
      check_frame(d, pen, pt, pre, 1'b1);
      DATA_VALID = 1'b0;
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
